if_id_hazard_stage: RTL
=======================

Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register combined with the hazard unit that feeds the ID/EX register.
- Captures the fetched instruction and PC, and decodes the source-register fields into IF_ID_Rs/IF_ID_Rt.
- Detects load-use hazards and generates the PC stall and the ID/EX bubble, applies taken-branch flush, and runs a HLT drain state machine that stops fetch and raises halted.

Parameters:
- DRAIN_CYCLES, 3: cycles between HLT leaving ID and halted asserting.
- NOP_INSTR, 16'h0000: value loaded into ID_instr on flush, bubble or drain.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- IF_instr  in  16  instruction from imem
- IF_pc  in  16  PC of IF_instr
- EX_memread  in  1  instruction in EX is LW
- EX_regtowrite  in  4  destination register of the EX instruction
- ex_branch_taken  in  1  taken branch/BR resolved in EX this cycle
- ID_instr  out  16  registered instruction
- ID_pc  out  16  registered PC
- ID_valid  out  1  ID_instr is a real instruction
- IF_ID_Rs  out  4  decoded first source register
- IF_ID_Rt  out  4  decoded second source register
- pc_wen  out  1  PC register write enable
- id_ex_bubble  out  1  forces all ID/EX control inputs to 0 this cycle
- halted  out  1  processor halted
- stall_count  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=0, async): ID_instr=NOP_INSTR, ID_pc=0, ID_valid=0, state=RUN, drain counter=0, stall_count=0, halted=0.
- Decode (combinational from ID_instr), opcode=ID_instr[15:12]:
  - IF_ID_Rs = ID_instr[11:8] for LHB(A)/LLB(B), else ID_instr[7:4].
  - IF_ID_Rt = ID_instr[11:8] for SW(9), else ID_instr[3:0].
  - rs_used = ID_valid and opcode not in {C,E,F}.
  - rt_used = ID_valid and opcode in {0,1,2,3,7,9}.
- Load-use stall, combinational:
  - stall = EX_memread & ((rs_used & EX_regtowrite==IF_ID_Rs) | (rt_used & EX_regtowrite==IF_ID_Rt)) & state==RUN & ~ex_branch_taken.
  - Register 0 gets no special treatment.
- Priority each cycle: flush > stall > halt-detect > normal. Behaviour per case:
  - Flush (ex_branch_taken=1, state==RUN): next ID_instr=NOP_INSTR, ID_valid=0; pc_wen=1; id_ex_bubble=1; any HLT in ID is discarded.
  - Stall: IF/ID holds its value; pc_wen=0; id_ex_bubble=1; stall_count increments, saturating at 16'hFFFF. Stalls last exactly 1 cycle, because the bubble clears EX_memread.
  - Halt-detect (state RUN, ID_valid, opcode F, no flush or stall): HLT passes to ID/EX normally (id_ex_bubble=0); pc_wen=0; next ID_valid=0 with ID_instr=NOP_INSTR; state becomes DRAIN; counter loads DRAIN_CYCLES.
  - Normal: ID_instr<=IF_instr, ID_pc<=IF_pc, ID_valid<=1; pc_wen=1; id_ex_bubble=0.
- FSM states RUN, DRAIN, HALTED:
  - RUN: behaviour as above.
  - DRAIN: pc_wen=0, id_ex_bubble=1, ID_valid held at 0, ex_branch_taken ignored (only younger, wrong-path instructions can be affected). Counter decrements each cycle; when counter==1 the next state is HALTED. With DRAIN_CYCLES=0, go straight to HALTED.
  - HALTED: halted=1 registered, pc_wen=0, id_ex_bubble=1. Exited only by reset.
- Reset mid-DRAIN or mid-stall returns all state to reset values immediately.
- halted is a registered output and rises the cycle after the counter reaches its final count.

Test Plan:
- Reset sequence: rst=0 asynchronously mid-cycle, then released. Required: ID_valid=0, pc_wen=1 after release, halted=0, stall_count=0. Streaming IF_instr=16'h1234, IF_pc=16'h0010 appears on ID_instr/ID_pc one cycle later with ID_valid=1.
- Load-use: ID_instr=16'h0312 (ADD r3,r1,r2), EX_memread=1, EX_regtowrite=1. Required: pc_wen=0, id_ex_bubble=1, ID_instr held 1 cycle, stall_count=1. Repeat with EX_regtowrite=5: no stall.
- SW decode: ID_instr=16'h9A45. Required: IF_ID_Rt=A, IF_ID_Rs=4. With EX_memread=1, EX_regtowrite=A: stall. LLB 16'hB7FF with EX_regtowrite=F: no stall (rt unused, Rs=7).
- Flush beats stall: hazardous ID instruction plus ex_branch_taken=1 in the same cycle. Required: pc_wen=1, next ID_valid=0, stall_count unchanged.
- HLT drain: ID_instr=16'hF000 valid, DRAIN_CYCLES=3. Required: pc_wen=0 from that cycle onward; ex_branch_taken pulsed during DRAIN is ignored; halted=1 exactly 4 clocks after HLT sat in ID; stays 1 until rst.
- Stall saturation: force 65536+ stall cycles. Required: stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and
// a HLT drain state machine that stops fetch and raises halted.
module if_id_hazard_stage #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] NOP_INSTR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IF_instr,
    input  logic [15:0] IF_pc,
    input  logic        EX_memread,
    input  logic [3:0]  EX_regtowrite,
    input  logic        ex_branch_taken,
    output logic [15:0] ID_instr,
    output logic [15:0] ID_pc,
    output logic        ID_valid,
    output logic [3:0]  IF_ID_Rs,
    output logic [3:0]  IF_ID_Rt,
    output logic        pc_wen,
    output logic        id_ex_bubble,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [15:0]        instr_reg, instr_next;
    logic [15:0]        pc_reg, pc_next;
    logic               valid_reg, valid_next;
    logic [15:0]        stall_cnt_reg, stall_cnt_next;
    logic               halted_reg, halted_next;

    logic [3:0] opcode;
    logic       rs_used;
    logic       rt_used;
    logic       flush;
    logic       stall;
    logic       halt_det;

    // Source-field decode; LHB/LLB keep their source in [11:8], SW keeps its data reg there.
    assign opcode   = instr_reg[15:12];
    assign IF_ID_Rs = (opcode == 4'hA || opcode == 4'hB) ? instr_reg[11:8] : instr_reg[7:4];
    assign IF_ID_Rt = (opcode == 4'h9) ? instr_reg[11:8] : instr_reg[3:0];
    assign rs_used  = valid_reg && !(opcode == 4'hC || opcode == 4'hE || opcode == 4'hF);
    assign rt_used  = valid_reg && (opcode == 4'h0 || opcode == 4'h1 || opcode == 4'h2 ||
                                    opcode == 4'h3 || opcode == 4'h7 || opcode == 4'h9);

    assign flush    = ex_branch_taken && (state_reg == RUN);
    assign stall    = EX_memread &&
                      ((rs_used && (EX_regtowrite == IF_ID_Rs)) ||
                       (rt_used && (EX_regtowrite == IF_ID_Rt))) &&
                      (state_reg == RUN) && !ex_branch_taken;
    assign halt_det = (state_reg == RUN) && valid_reg && (opcode == 4'hF) && !flush && !stall;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        instr_next     = instr_reg;
        pc_next        = pc_reg;
        valid_next     = valid_reg;
        stall_cnt_next = stall_cnt_reg;
        halted_next    = halted_reg;
        pc_wen         = 1'b0;
        id_ex_bubble   = 1'b0;

        case (state_reg)
            RUN: begin
                if (flush) begin
                    instr_next   = NOP_INSTR;
                    valid_next   = 1'b0;
                    pc_wen       = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (stall) begin
                    id_ex_bubble = 1'b1;
                    if (stall_cnt_reg != 16'hFFFF) begin
                        stall_cnt_next = stall_cnt_reg + 16'd1;
                    end
                end else if (halt_det) begin
                    // The HLT itself still goes down the pipe; only fetch stops.
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    cnt_next   = CNT_W'(DRAIN_CYCLES);
                    if (DRAIN_CYCLES == 0) begin
                        state_next  = HALTED;
                        halted_next = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    instr_next = IF_instr;
                    pc_next    = IF_pc;
                    valid_next = 1'b1;
                    pc_wen     = 1'b1;
                end
            end
            DRAIN: begin
                id_ex_bubble = 1'b1;
                instr_next   = NOP_INSTR;
                valid_next   = 1'b0;
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next    = '0;
                    state_next  = HALTED;
                    halted_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HALTED: begin
                id_ex_bubble = 1'b1;
                halted_next  = 1'b1;
                instr_next   = NOP_INSTR;
                valid_next   = 1'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            instr_reg     <= NOP_INSTR;
            pc_reg        <= 16'h0000;
            valid_reg     <= 1'b0;
            stall_cnt_reg <= 16'h0000;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            instr_reg     <= instr_next;
            pc_reg        <= pc_next;
            valid_reg     <= valid_next;
            stall_cnt_reg <= stall_cnt_next;
            halted_reg    <= halted_next;
        end
    end

    assign ID_instr    = instr_reg;
    assign ID_pc       = pc_reg;
    assign ID_valid    = valid_reg;
    assign stall_count = stall_cnt_reg;
    assign halted      = halted_reg;

endmodule
